// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 15x64 register file with two
// combinational read ports, sticky processor status. Optional macro WB_BYPASS_EN.
module writeback_regfile #(
    parameter int          NREG  = 15,
    parameter int          XLEN  = 64,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            W_stall,
    input  logic            W_bubble,
    input  logic [3:0]      m_stat,
    input  logic [3:0]      M_icode,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] m_valM,
    input  logic [3:0]      M_dstE,
    input  logic [3:0]      M_dstM,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] rvalA,
    output logic [XLEN-1:0] rvalB,
    output logic [3:0]      W_stat,
    output logic [3:0]      W_icode,
    output logic [XLEN-1:0] W_valE,
    output logic [XLEN-1:0] W_valM,
    output logic [3:0]      W_dstE,
    output logic [3:0]      W_dstM,
    output logic [3:0]      Stat,
    output logic            halted
);

    localparam logic [3:0] SAOK  = 4'd1;
    localparam logic [3:0] INOP  = 4'd1;

    logic [XLEN-1:0] regFile [NREG];
    logic            commitEn;
    logic            wLoad;
    logic [3:0]      dstE, dstM, srcAv, srcBv;

    // Any ID outside the architectural range behaves exactly like "no register".
    function automatic logic [3:0] sanitize(input logic [3:0] id);
        return (int'(id) < NREG) ? id : RNONE;
    endfunction

    assign dstE     = sanitize(W_dstE);
    assign dstM     = sanitize(W_dstM);
    assign srcAv    = sanitize(srcA);
    assign srcBv    = sanitize(srcB);
    assign commitEn = (W_stat == SAOK) && !halted;
    assign wLoad    = !halted && !W_stall;

    always_ff @(posedge clk) begin
        if (rst || (wLoad && W_bubble)) begin
            W_stat  <= SAOK;
            W_icode <= INOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (wLoad) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

    // valM is written last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else if (commitEn) begin
            if (dstE != RNONE) regFile[dstE] <= W_valE;
            if (dstM != RNONE) regFile[dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Stat   <= SAOK;
            halted <= 1'b0;
        end else if (!halted && W_stat != SAOK) begin
            Stat   <= W_stat;
            halted <= 1'b1;
        end
    end

    always_comb begin
        rvalA = '0;
        rvalB = '0;
        if (srcAv != RNONE) rvalA = regFile[srcAv];
        if (srcBv != RNONE) rvalB = regFile[srcBv];
`ifdef WB_BYPASS_EN
        // Forward the commit happening at the next edge; valM shadows valE.
        if (commitEn && srcAv != RNONE) begin
            if (srcAv == dstM)      rvalA = W_valM;
            else if (srcAv == dstE) rvalA = W_valE;
        end
        if (commitEn && srcBv != RNONE) begin
            if (srcBv == dstM)      rvalB = W_valM;
            else if (srcBv == dstE) rvalB = W_valE;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst, W_stall, W_bubble;
    logic [3:0]  m_stat, M_icode, M_dstE, M_dstM, srcA, srcB;
    logic [63:0] M_valE, m_valM, rvalA, rvalB, W_valE, W_valM;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, Stat;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    writeback_regfile dut (
        .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .srcA(srcA), .srcB(srcB),
        .rvalA(rvalA), .rvalB(rvalB), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .Stat(Stat), .halted(halted)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [63:0] mR [16];
    logic [3:0]  mWstat, mWicode, mWdstE, mWdstM, mStat;
    logic [63:0] mWvalE, mWvalM;
    logic        mHalted;

    function automatic void modelStep();
        bit wasHalted;
        wasHalted = mHalted;
        if (rst) begin
            for (int i = 0; i < 16; i++) mR[i] = 64'd0;
            mWstat = 1; mWicode = 1; mWvalE = 0; mWvalM = 0; mWdstE = 4'hF; mWdstM = 4'hF;
            mStat = 1; mHalted = 1'b0;
            return;
        end
        if (mWstat == 1 && !wasHalted) begin
            if (mWdstE != 4'hF) mR[mWdstE] = mWvalE;
            if (mWdstM != 4'hF) mR[mWdstM] = mWvalM;
        end
        if (!wasHalted && mWstat != 1) begin
            mStat = mWstat;
            mHalted = 1'b1;
        end
        if (!wasHalted && !W_stall) begin
            if (W_bubble) begin
                mWstat = 1; mWicode = 1; mWvalE = 0; mWvalM = 0; mWdstE = 4'hF; mWdstM = 4'hF;
            end else begin
                mWstat = m_stat; mWicode = M_icode; mWvalE = M_valE; mWvalM = m_valM;
                mWdstE = M_dstE; mWdstM = M_dstM;
            end
        end
    endfunction

    function automatic logic [63:0] mRead(input logic [3:0] s);
        if (s == 4'hF) return 64'd0;
        if (BYP && mWstat == 1 && !mHalted) begin
            if (s == mWdstM) return mWvalM;
            if (s == mWdstE) return mWvalE;
        end
        return mR[s];
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic setM(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        m_stat = st; M_icode = ic; M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
    endtask

    task automatic doReset();
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        setM(1, 1, 0, 0, 4'hF, 4'hF);
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        srcA = 4'd3; srcB = 4'hF;
        doReset();
        vectors++;
        if (W_icode !== 4'd1 || W_stat !== 4'd1 || W_dstE !== 4'hF || W_dstM !== 4'hF ||
            W_valE !== 64'd0 || W_valM !== 64'd0 || rvalA !== 64'd0 || Stat !== 4'd1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: icode=%0d stat=%0d dstE=%h dstM=%h valE=%h valM=%h rvalA=%h Stat=%0d halted=%b (want 1 1 f f 0 0 0 1 0)",
                     W_icode, W_stat, W_dstE, W_dstM, W_valE, W_valM, rvalA, Stat, halted);
        end
    endtask

    task automatic test_latency();
        logic [63:0] early;
        doReset();
        setM(1, 3, 64'h2A, 0, 4'd2, 4'hF);
        srcA = 4'd2;
        tick();
        setM(1, 1, 0, 0, 4'hF, 4'hF);
        #1;
        early = BYP ? 64'h2A : 64'h0;
        vectors++;
        if (W_valE !== 64'h2A || rvalA !== early) begin
            miscompares++;
            $display("FAIL latency_edge1: W_valE=%h rvalA=%h, want 2a %h", W_valE, rvalA, early);
        end
        tick();
        vectors++;
        if (rvalA !== 64'h2A) begin
            miscompares++;
            $display("FAIL latency_edge2: rvalA=%h, want 2a", rvalA);
        end
    endtask

    task automatic test_popq();
        doReset();
        setM(1, 4'hB, 64'h8, 64'h55, 4'd4, 4'd4);
        tick();
        setM(1, 1, 0, 0, 4'hF, 4'hF);
        tick();
        srcB = 4'd4; #1;
        vectors++;
        if (rvalB !== 64'h55) begin
            miscompares++;
            $display("FAIL popq_valM_wins: R[4]=%h, want 55", rvalB);
        end
    endtask

    task automatic test_stall_bubble();
        doReset();
        setM(1, 3, 64'h66, 0, 4'd6, 4'hF);
        tick();
        W_stall = 1'b1;
        setM(1, 5, 64'h77, 64'h1, 4'd7, 4'd8);
        tick();
        vectors++;
        if (W_valE !== 64'h66 || W_dstE !== 4'd6 || W_icode !== 4'd3 || W_dstM !== 4'hF) begin
            miscompares++;
            $display("FAIL stall_hold: valE=%h dstE=%h icode=%h dstM=%h, want 66 6 3 f", W_valE, W_dstE, W_icode, W_dstM);
        end
        W_bubble = 1'b1;
        tick();
        vectors++;
        if (W_valE !== 64'h66 || W_dstE !== 4'd6) begin
            miscompares++;
            $display("FAIL stall_over_bubble: valE=%h dstE=%h, want 66 6", W_valE, W_dstE);
        end
        W_stall = 1'b0;
        setM(1, 3, 64'h88, 0, 4'd6, 4'hF);
        tick();
        vectors++;
        if (W_icode !== 4'd1 || W_dstE !== 4'hF || W_dstM !== 4'hF) begin
            miscompares++;
            $display("FAIL bubble_load: icode=%h dstE=%h dstM=%h, want 1 f f", W_icode, W_dstE, W_dstM);
        end
        W_bubble = 1'b0;
        setM(1, 1, 0, 0, 4'hF, 4'hF);
        tick();
        srcA = 4'd6; srcB = 4'd7; #1;
        vectors++;
        if (rvalA !== 64'h66 || rvalB !== 64'h0) begin
            miscompares++;
            $display("FAIL bubble_no_write: R[6]=%h R[7]=%h, want 66 0", rvalA, rvalB);
        end
    endtask

    task automatic test_exception();
        doReset();
        setM(1, 3, 64'h11, 0, 4'd5, 4'hF);
        tick();
        setM(3, 3, 64'h99, 0, 4'd5, 4'hF);
        tick();
        setM(1, 3, 64'h123, 0, 4'd7, 4'hF);
        tick();
        tick(); tick();
        srcA = 4'd5; srcB = 4'd7; #1;
        vectors++;
        if (rvalA !== 64'h11 || rvalB !== 64'h0 || Stat !== 4'd3 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL exception_freeze: R[5]=%h R[7]=%h Stat=%0d halted=%b, want 11 0 3 1", rvalA, rvalB, Stat, halted);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (Stat !== 4'd1 || halted !== 1'b0 || rvalA !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_from_halt: Stat=%0d halted=%b R[5]=%h, want 1 0 0", Stat, halted, rvalA);
        end
    endtask

    task automatic test_halt();
        doReset();
        setM(2, 0, 0, 0, 4'hF, 4'hF);
        tick();
        vectors++;
        if (W_icode !== 4'd0 || W_stat !== 4'd2 || Stat !== 4'd1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_in_W: icode=%h wstat=%0d Stat=%0d halted=%b, want 0 2 1 0", W_icode, W_stat, Stat, halted);
        end
        tick();
        vectors++;
        if (Stat !== 4'd2 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_status: Stat=%0d halted=%b, want 2 1", Stat, halted);
        end
        setM(1, 3, 64'h5, 0, 4'd3, 4'hF);
        tick(); tick();
        vectors++;
        if (W_icode !== 4'd0 || W_stat !== 4'd2 || W_dstE !== 4'hF || Stat !== 4'd2) begin
            miscompares++;
            $display("FAIL halt_W_frozen: icode=%h wstat=%0d dstE=%h Stat=%0d, want 0 2 f 2", W_icode, W_stat, W_dstE, Stat);
        end
    endtask

    task automatic test_random();
        logic [63:0] eA, eB;
        doReset();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            W_stall  = ($urandom_range(0, 9) == 0);
            W_bubble = ($urandom_range(0, 9) == 0);
            m_stat   = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            M_icode  = 4'($urandom_range(0, 11));
            M_valE   = {$urandom, $urandom};
            m_valM   = {$urandom, $urandom};
            M_dstE   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            M_dstM   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            tick();
            srcA = 4'($urandom_range(0, 15));
            srcB = 4'($urandom_range(0, 15));
            #1;
            eA = mRead(srcA);
            eB = mRead(srcB);
            vectors++;
            if (W_stat !== mWstat || W_icode !== mWicode || W_valE !== mWvalE || W_valM !== mWvalM ||
                W_dstE !== mWdstE || W_dstM !== mWdstM || Stat !== mStat || halted !== mHalted ||
                rvalA !== eA || rvalB !== eB) begin
                miscompares++;
                $display("FAIL random[%0d]: got stat=%h ic=%h vE=%h vM=%h dE=%h dM=%h S=%h h=%b A=%h B=%h want %h %h %h %h %h %h %h %b %h %h",
                         n, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, Stat, halted, rvalA, rvalB,
                         mWstat, mWicode, mWvalE, mWvalM, mWdstE, mWdstM, mStat, mHalted, eA, eB);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        srcA = 4'hF; srcB = 4'hF;
        setM(1, 1, 0, 0, 4'hF, 4'hF);
        for (int i = 0; i < 16; i++) mR[i] = 64'd0;
        mWstat = 1; mWicode = 1; mWvalE = 0; mWvalM = 0; mWdstE = 4'hF; mWdstM = 4'hF;
        mStat = 1; mHalted = 1'b0;
        test_reset();
        test_latency();
        test_popq();
        test_stall_bubble();
        test_exception();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
